// File: rtl/decodificador_rotativo_if.sv
// Encoder pin/result bundle for decodificador_rotativo.
// The host side drives the raw phases and clear; the decoder returns events and position.
interface decodificador_rotativo_if #(
  parameter int unsigned CNT_W = 8
);
  logic             ROTA;
  logic             ROTB;
  logic             CLR;
  logic             EV;
  logic             IZ;
  logic [CNT_W-1:0] POS;
  logic             ERR;

  modport master (output ROTA, ROTB, CLR, input EV, IZ, POS, ERR);
  modport slave  (input ROTA, ROTB, CLR, output EV, IZ, POS, ERR);
endinterface

// File: rtl/decodificador_rotativo.sv
// Rotary/quadrature encoder front end: per-phase synchroniser and glitch filter,
// x1/x4 direction decode, signed position counter with wrap or saturation.
module decodificador_rotativo #(
  parameter int unsigned FILT_LEN = 4,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned MODE_X4  = 0,
  parameter int unsigned SAT      = 0
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  decodificador_rotativo_if.slave bus
);

  localparam int unsigned ARM_CYC = FILT_LEN + 3;
  localparam int unsigned ARM_W   = $clog2(ARM_CYC);
  localparam int unsigned FC_W    = $clog2(FILT_LEN);
  localparam logic [CNT_W-1:0] POS_MAX = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] POS_MIN = {1'b1, {(CNT_W-1){1'b0}}};

  typedef enum logic {ST_ARM, ST_RUN} state_t;

  // Phase vectors are {A, B}.
  logic [1:0]            sync1_q, sync2_q;
  logic [1:0]            filt_q, filt_d;
  logic [1:0]            prev_q, prev_d;
  logic [1:0][FC_W-1:0]  fcnt_q, fcnt_d;
  logic [ARM_W-1:0]      arm_q, arm_d;
  state_t                state_q, state_d;
  logic                  ev_q, ev_d;
  logic                  err_q, err_d;
  logic                  iz_q, iz_d;
  logic [CNT_W-1:0]      pos_q, pos_d;
  logic                  step;
  logic                  left;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q <= '0;
      sync2_q <= '0;
      filt_q  <= '0;
      prev_q  <= '0;
      fcnt_q  <= '0;
      arm_q   <= '0;
      state_q <= ST_ARM;
      ev_q    <= 1'b0;
      err_q   <= 1'b0;
      iz_q    <= 1'b0;
      pos_q   <= '0;
    end else begin
      sync1_q <= {bus.ROTA, bus.ROTB};
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      prev_q  <= prev_d;
      fcnt_q  <= fcnt_d;
      arm_q   <= arm_d;
      state_q <= state_d;
      ev_q    <= ev_d;
      err_q   <= err_d;
      iz_q    <= iz_d;
      pos_q   <= pos_d;
    end
  end

  always_comb begin
    state_d = state_q;
    arm_d   = arm_q;
    filt_d  = filt_q;
    prev_d  = filt_q;
    fcnt_d  = fcnt_q;
    ev_d    = 1'b0;
    err_d   = 1'b0;
    iz_d    = iz_q;
    pos_d   = pos_q;
    step    = 1'b0;
    left    = 1'b0;

    unique case (state_q)
      ST_ARM: begin
        // Lock onto the idle pin levels so released-high pins never look like an edge.
        filt_d = sync2_q;
        prev_d = sync2_q;
        fcnt_d = '0;
        if (arm_q == ARM_W'(ARM_CYC - 1)) state_d = ST_RUN;
        else                              arm_d   = arm_q + 1'b1;
      end
      ST_RUN: begin
        for (int unsigned i = 0; i < 2; i++) begin
          if (sync2_q[i] != filt_q[i]) begin
            if (fcnt_q[i] == FC_W'(FILT_LEN - 1)) begin
              filt_d[i] = sync2_q[i];
              fcnt_d[i] = '0;
            end else begin
              fcnt_d[i] = fcnt_q[i] + 1'b1;
            end
          end else begin
            fcnt_d[i] = '0;
          end
        end

        if (MODE_X4 != 0) begin
          if ((prev_q ^ filt_q) == 2'b11) begin
            err_d = 1'b1;
          end else if (prev_q != filt_q) begin
            step = 1'b1;
            unique case ({prev_q, filt_q})
              4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: left = 1'b0;
              default:                                left = 1'b1;
            endcase
          end
        end else if (!prev_q[1] && filt_q[1]) begin
          step = 1'b1;
          left = filt_q[0];
        end

        if (step) begin
          ev_d = 1'b1;
          iz_d = left;
          if (left) begin
            if (SAT == 0 || pos_q != POS_MIN) pos_d = pos_q - 1'b1;
          end else begin
            if (SAT == 0 || pos_q != POS_MAX) pos_d = pos_q + 1'b1;
          end
        end
      end
      default: state_d = ST_ARM;
    endcase

    if (bus.CLR) pos_d = '0;
  end

  assign bus.EV  = ev_q;
  assign bus.ERR = err_q;
  assign bus.IZ  = iz_q;
  assign bus.POS = pos_q;

endmodule

// File: tb/tb_decodificador_rotativo.sv
// Directed bench for decodificador_rotativo: four instances (x1, x4, 4-bit saturating,
// 4-bit wrapping) share raw pin stimulus; each phase checks the relevant instances.
module tb_decodificador_rotativo;

  logic clk;
  logic rst_n;
  logic rota, rotb, clr;

  int n_tests = 0;
  int n_fail  = 0;
  int ev_x1, ev_x4, err_x1, err_x4, ev_sat, ev_wrap;

  decodificador_rotativo_if #(.CNT_W(8)) if_x1 ();
  decodificador_rotativo_if #(.CNT_W(8)) if_x4 ();
  decodificador_rotativo_if #(.CNT_W(4)) if_sat ();
  decodificador_rotativo_if #(.CNT_W(4)) if_wrap ();

  assign if_x1.ROTA   = rota;  assign if_x1.ROTB   = rotb;  assign if_x1.CLR   = clr;
  assign if_x4.ROTA   = rota;  assign if_x4.ROTB   = rotb;  assign if_x4.CLR   = clr;
  assign if_sat.ROTA  = rota;  assign if_sat.ROTB  = rotb;  assign if_sat.CLR  = clr;
  assign if_wrap.ROTA = rota;  assign if_wrap.ROTB = rotb;  assign if_wrap.CLR = clr;

  decodificador_rotativo #(.FILT_LEN(4), .CNT_W(8), .MODE_X4(0), .SAT(0))
    u_x1 (.CLK(clk), .RST_N(rst_n), .bus(if_x1));
  decodificador_rotativo #(.FILT_LEN(4), .CNT_W(8), .MODE_X4(1), .SAT(0))
    u_x4 (.CLK(clk), .RST_N(rst_n), .bus(if_x4));
  decodificador_rotativo #(.FILT_LEN(4), .CNT_W(4), .MODE_X4(0), .SAT(1))
    u_sat (.CLK(clk), .RST_N(rst_n), .bus(if_sat));
  decodificador_rotativo #(.FILT_LEN(4), .CNT_W(4), .MODE_X4(0), .SAT(0))
    u_wrap (.CLK(clk), .RST_N(rst_n), .bus(if_wrap));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic a;
    logic b;
    int   x1_ev;
    int   x1_pos;
    int   x1_iz;
    int   x4_ev;
    int   x4_pos;
    int   x4_iz;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic zero_counts();
    ev_x1 = 0; ev_x4 = 0; err_x1 = 0; err_x4 = 0; ev_sat = 0; ev_wrap = 0;
  endtask

  // Advance n cycles, sampling 1 time unit after each rising edge.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      ev_x1   += int'(if_x1.EV);
      ev_x4   += int'(if_x4.EV);
      err_x1  += int'(if_x1.ERR);
      err_x4  += int'(if_x4.ERR);
      ev_sat  += int'(if_sat.EV);
      ev_wrap += int'(if_wrap.EV);
    end
  endtask

  task automatic apply_reset(input logic a, input logic b);
    rota  = a;
    rotb  = b;
    clr   = 1'b0;
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(12);
    zero_counts();
  endtask

  task automatic x1_rise(input int n);
    for (int k = 0; k < n; k++) begin
      rota = 1'b1; tick(8);
      rota = 1'b0; tick(8);
    end
  endtask

  initial begin
    int lat;
    logic [1:0] seq [4];

    tbl[0] = '{1'b1, 1'b0, 1, 1, 0, 1,  1, 0};
    tbl[1] = '{1'b0, 1'b0, 0, 1, 0, 1,  0, 1};
    tbl[2] = '{1'b1, 1'b0, 1, 2, 0, 1,  1, 0};
    tbl[3] = '{1'b0, 1'b0, 0, 2, 0, 1,  0, 1};
    tbl[4] = '{1'b1, 1'b0, 1, 3, 0, 1,  1, 0};
    tbl[5] = '{1'b0, 1'b0, 0, 3, 0, 1,  0, 1};
    tbl[6] = '{1'b0, 1'b1, 0, 3, 0, 1, -1, 1};
    tbl[7] = '{1'b1, 1'b1, 1, 2, 1, 1, -2, 1};
    tbl[8] = '{1'b0, 1'b1, 0, 2, 1, 1, -1, 0};
    tbl[9] = '{1'b1, 1'b1, 1, 1, 1, 1, -2, 1};

    // Idle-high pins through reset release.
    rota = 1'b1; rotb = 1'b1; clr = 1'b0; rst_n = 1'b0;
    zero_counts();
    tick(3);
    chk("rst_ev",  int'(if_x1.EV), 0);
    chk("rst_iz",  int'(if_x1.IZ), 0);
    chk("rst_pos", int'(if_x1.POS), 0);
    chk("rst_err", int'(if_x4.ERR), 0);
    rst_n = 1'b1;
    zero_counts();
    tick(30);
    chk("idle_ev_x1",  ev_x1, 0);
    chk("idle_ev_x4",  ev_x4, 0);
    chk("idle_err_x4", err_x4, 0);
    chk("idle_pos_x1", int'($signed(if_x1.POS)), 0);
    chk("idle_pos_x4", int'($signed(if_x4.POS)), 0);

    // Raw edge to EV latency.
    apply_reset(1'b0, 1'b0);
    rota = 1'b1;
    lat  = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      tick(1);
      if (if_x1.EV) lat = k;
    end
    chk("x1_latency", lat, 7);

    // Table of single-level changes, both decode modes side by side.
    apply_reset(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      rota = tbl[i].a;
      rotb = tbl[i].b;
      zero_counts();
      tick(10);
      chk($sformatf("tbl%0d_x1_ev", i),  ev_x1, tbl[i].x1_ev);
      chk($sformatf("tbl%0d_x1_pos", i), int'($signed(if_x1.POS)), tbl[i].x1_pos);
      chk($sformatf("tbl%0d_x1_iz", i),  int'(if_x1.IZ), tbl[i].x1_iz);
      chk($sformatf("tbl%0d_x1_err", i), err_x1, 0);
      chk($sformatf("tbl%0d_x4_ev", i),  ev_x4, tbl[i].x4_ev);
      chk($sformatf("tbl%0d_x4_pos", i), int'($signed(if_x4.POS)), tbl[i].x4_pos);
      chk($sformatf("tbl%0d_x4_iz", i),  int'(if_x4.IZ), tbl[i].x4_iz);
      chk($sformatf("tbl%0d_x4_err", i), err_x4, 0);
    end

    // Glitch filter boundary: 3-cycle pulse rejected, 4-cycle pulse accepted.
    apply_reset(1'b0, 1'b0);
    rota = 1'b1; tick(3);
    rota = 1'b0; tick(12);
    chk("pulse3_ev",  ev_x1, 0);
    chk("pulse3_pos", int'($signed(if_x1.POS)), 0);
    rota = 1'b1; tick(4);
    rota = 1'b0; tick(12);
    chk("pulse4_ev",  ev_x1, 1);
    chk("pulse4_pos", int'($signed(if_x1.POS)), 1);

    // x4 full right cycle, then an illegal double change.
    apply_reset(1'b0, 1'b0);
    seq[0] = 2'b10; seq[1] = 2'b11; seq[2] = 2'b01; seq[3] = 2'b00;
    for (int i = 0; i < 4; i++) begin
      rota = seq[i][1];
      rotb = seq[i][0];
      tick(10);
    end
    chk("x4_cycle_ev",  ev_x4, 4);
    chk("x4_cycle_pos", int'($signed(if_x4.POS)), 4);
    chk("x4_cycle_iz",  int'(if_x4.IZ), 0);
    chk("x4_cycle_err", err_x4, 0);
    zero_counts();
    rota = 1'b1; rotb = 1'b1;
    tick(10);
    chk("x4_illegal_err", err_x4, 1);
    chk("x4_illegal_ev",  ev_x4, 0);
    chk("x4_illegal_pos", int'($signed(if_x4.POS)), 4);
    chk("x4_illegal_iz",  int'(if_x4.IZ), 0);

    // 4-bit counter: saturate vs wrap over 10 right steps.
    apply_reset(1'b0, 1'b0);
    x1_rise(10);
    chk("sat_ev",       ev_sat, 10);
    chk("sat_pos",      int'($signed(if_sat.POS)), 7);
    chk("wrap_ev",      ev_wrap, 10);
    chk("wrap_pos",     int'($signed(if_wrap.POS)), -6);
    chk("wrap_pos_raw", int'(if_wrap.POS), 10);

    // CLR coincident with a step, then reset mid-filter.
    apply_reset(1'b0, 1'b0);
    x1_rise(5);
    chk("pre_clr_pos", int'($signed(if_x1.POS)), 5);
    rota = 1'b1;
    tick(6);
    clr = 1'b1;
    tick(1);
    chk("clr_step_ev",  int'(if_x1.EV), 1);
    chk("clr_step_pos", int'($signed(if_x1.POS)), 0);
    clr = 1'b0;
    tick(1);
    chk("clr_ev_single", int'(if_x1.EV), 0);
    rota = 1'b0; tick(8);
    rotb = 1'b1; tick(8);
    rota = 1'b1; tick(8);
    chk("left_pos", int'($signed(if_x1.POS)), -1);
    chk("left_iz",  int'(if_x1.IZ), 1);
    rota = 1'b0;
    tick(3);
    rst_n = 1'b0;
    #1;
    chk("midrst_ev",  int'(if_x1.EV), 0);
    chk("midrst_iz",  int'(if_x1.IZ), 0);
    chk("midrst_pos", int'(if_x1.POS), 0);
    chk("midrst_err", int'(if_x4.ERR), 0);
    tick(2);
    rst_n = 1'b1;
    zero_counts();
    tick(25);
    chk("post_rst_ev",  ev_x1, 0);
    chk("post_rst_pos", int'($signed(if_x1.POS)), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
